// File: rtl/seq_divider_rv32m.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow finish in one cycle; everything else takes XLEN iterations.
module seq_divider_rv32m #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_valid_i,
  input  logic [1:0]      div_op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] result_o,
  output logic            div_ready_o,
  output logic            div_busy_o
);

  // Handshake: a request is taken on the rising edge where state is IDLE, div_valid_i=1 and
  // flush_i=0; operands need only be valid on that edge. div_ready_o is a one-cycle pulse in
  // DONE with result_o valid in the same cycle; there is no back-pressure on the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);

  state_t           state;
  logic             op_rem;
  logic             is_signed;
  logic             sign_a;
  logic             sign_b;
  logic [XLEN-1:0]  dividend;
  logic [XLEN-1:0]  divisor;
  logic [XLEN-1:0]  rem;
  logic [CNT_W-1:0] count;

  logic             req_signed;
  logic [XLEN-1:0]  abs_a;
  logic [XLEN-1:0]  abs_b;
  logic             b_zero;
  logic             ovf;
  logic [XLEN-1:0]  special_res;

  assign req_signed = ~div_op_i[0];
  assign abs_a      = (req_signed && operand_a_i[XLEN-1]) ? -operand_a_i : operand_a_i;
  assign abs_b      = (req_signed && operand_b_i[XLEN-1]) ? -operand_b_i : operand_b_i;
  assign b_zero     = (operand_b_i == '0);
  assign ovf        = req_signed && (operand_a_i == INT_MIN) && (operand_b_i == '1);
  assign special_res = b_zero ? (div_op_i[1] ? operand_a_i : '1)
                              : (div_op_i[1] ? '0 : INT_MIN);

  // The dividend register doubles as the quotient: each step shifts out a dividend bit
  // and shifts in the new quotient bit.
  logic [XLEN-1:0] rem_shift;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quot_next;
  logic [XLEN-1:0] quot_fix;
  logic [XLEN-1:0] rem_fix;

  assign rem_shift = {rem[XLEN-2:0], dividend[XLEN-1]};
  assign diff      = {1'b0, rem_shift} - {1'b0, divisor};
  assign ge        = ~diff[XLEN];
  assign rem_next  = ge ? diff[XLEN-1:0] : rem_shift;
  assign quot_next = {dividend[XLEN-2:0], ge};
  assign quot_fix  = (is_signed && (sign_a ^ sign_b)) ? -quot_next : quot_next;
  assign rem_fix   = (is_signed && sign_a) ? -rem_next : rem_next;

  assign div_busy_o = (state == CALC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_rem      <= 1'b0;
      is_signed   <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      dividend    <= '0;
      divisor     <= '0;
      rem         <= '0;
      count       <= '0;
      result_o    <= '0;
      div_ready_o <= 1'b0;
    end else begin
      div_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (div_valid_i && !flush_i) begin
            op_rem    <= div_op_i[1];
            is_signed <= req_signed;
            sign_a    <= req_signed & operand_a_i[XLEN-1];
            sign_b    <= req_signed & operand_b_i[XLEN-1];
            dividend  <= abs_a;
            divisor   <= abs_b;
            rem       <= '0;
            count     <= '0;
            if (b_zero || ovf) begin
              result_o    <= special_res;
              div_ready_o <= 1'b1;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            rem      <= rem_next;
            dividend <= quot_next;
            count    <= count + CNT_W'(1);
            if (count == LAST) begin
              result_o    <= op_rem ? rem_fix : quot_fix;
              div_ready_o <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_rv32m.sv
// Bench for seq_divider_rv32m: directed RV32M cases, flush/reset aborts, back-to-back
// requests and randomized operations checked against an arithmetic reference model.
module tb_seq_divider_rv32m;

  logic        clk;
  logic        rst_n;
  logic        div_valid;
  logic [1:0]  div_op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic [31:0] result;
  logic        div_ready;
  logic        div_busy;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result = '0;

  seq_divider_rv32m #(.XLEN(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .div_valid_i (div_valid),
    .div_op_i    (div_op),
    .operand_a_i (operand_a),
    .operand_b_i (operand_b),
    .flush_i     (flush),
    .result_o    (result),
    .div_ready_o (div_ready),
    .div_busy_o  (div_busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    div_valid = 1'b0;
    flush     = 1'b0;
    div_op    = 2'b00;
    operand_a = '0;
    operand_b = '0;
  endtask

  // Waits (bounded) for the ready pulse; lat counts cycles since the accept edge.
  task automatic wait_ready(output int lat, output int busy_cycles);
    lat = 1;
    busy_cycles = 0;
    while (!div_ready && lat < 40) begin
      if (div_busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    if (div_busy) busy_cycles++;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    int lat, busy_cycles, lat_exp;
    lat_exp = is_special(op, a, b) ? 1 : 33;
    exp_q.push_back(exp);
    @(negedge clk);
    div_valid = 1'b1;
    div_op    = op;
    operand_a = a;
    operand_b = b;
    @(negedge clk);
    div_valid = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
    wait_ready(lat, busy_cycles);
    check({tag, " latency"}, 32'(lat), 32'(lat_exp));
    check({tag, " busy_cycles"}, 32'(busy_cycles), 32'(lat_exp - 1));
    check({tag, " result"}, result, exp_q.pop_front());
    last_result = exp;
    @(negedge clk);
    check({tag, " ready_one_cycle"}, 32'(div_ready), 32'd0);
  endtask

  task automatic count_ready(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (div_ready) pulses++;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int pulses, lat, busy_cycles;
    logic [1:0]  op;
    logic [31:0] a, b;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset result", result, 32'd0);
    check("reset ready", 32'(div_ready), 32'd0);
    check("reset busy", 32'(div_busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "DIV -7/2");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "REM -7/2");
    run_op(2'b01, 32'd100, 32'd7, 32'd14, "DIVU 100/7");
    run_op(2'b11, 32'd100, 32'd7, 32'd2, "REMU 100/7");
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, "DIVU max/1");
    run_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, "DIVU 5/0");
    run_op(2'b10, 32'd5, 32'd0, 32'd5, "REM 5/0");
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV ovf");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "REM ovf");
    run_op(2'b01, 32'd1000, 32'd7, 32'd142, "DIVU 1000/7");

    // Flush in the tenth cycle after accept aborts the operation.
    @(negedge clk);
    div_valid = 1'b1; div_op = 2'b01; operand_a = 32'd77; operand_b = 32'd5;
    @(negedge clk);
    div_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("flush busy_before", 32'(div_busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush idle_after", 32'(div_busy), 32'd0);
    check("flush result_kept", result, last_result);
    count_ready(40, pulses);
    check("flush no_ready", 32'(pulses), 32'd0);
    check("flush result_still_kept", result, last_result);
    run_op(2'b01, 32'd9, 32'd3, 32'd3, "DIVU 9/3 after flush");

    // Asynchronous reset in the fifth cycle after accept.
    @(negedge clk);
    div_valid = 1'b1; div_op = 2'b00; operand_a = 32'd1234; operand_b = 32'd10;
    @(negedge clk);
    div_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset result", result, 32'd0);
    check("async_reset busy", 32'(div_busy), 32'd0);
    check("async_reset ready", 32'(div_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_ready(40, pulses);
    check("async_reset no_ready", 32'(pulses), 32'd0);
    last_result = '0;

    // Back-to-back: valid held through DONE; second request is taken only from IDLE.
    @(negedge clk);
    div_valid = 1'b1; div_op = 2'b01; operand_a = 32'd100; operand_b = 32'd7;
    @(negedge clk);
    wait_ready(lat, busy_cycles);
    check("b2b first latency", 32'(lat), 32'd33);
    check("b2b first result", result, 32'd14);
    div_op = 2'b11; operand_a = 32'd50; operand_b = 32'd6;
    @(negedge clk);
    check("b2b idle_gap busy", 32'(div_busy), 32'd0);
    check("b2b idle_gap ready", 32'(div_ready), 32'd0);
    @(negedge clk);
    div_valid = 1'b0;
    wait_ready(lat, busy_cycles);
    check("b2b second latency", 32'(lat), 32'd33);
    check("b2b second result", result, 32'd2);
    @(negedge clk);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 100));
        4: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(op, a, b, ref_div(op, a, b), $sformatf("rand%0d op=%0d a=%08h b=%08h", i, op, a, b));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
